// File: rtl/fifo_priority_nch.sv
// NUM_CH independent synchronous FIFOs sharing one registered read port.
// Arbitration is strict priority (channel 0 highest) or priority with aging-based starvation relief.
module fifo_priority_nch #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int NUM_CH       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     din,
    input  logic                             rd_en,
    input  logic                             arb_mode,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
    output logic [2:0]                       dout_ch,
    output logic [NUM_CH-1:0]                full,
    output logic [NUM_CH-1:0]                empty,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] ch_count,
    output logic [NUM_CH-1:0]                overflow,
    output logic                             underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem    [NUM_CH][DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CH];
    logic [PW-1:0]         rd_ptr [NUM_CH];
    logic [3:0]            age    [NUM_CH];
    logic [NUM_CH-1:0]     cand;
    logic [NUM_CH-1:0]     starving;
    logic [2:0]            grant;
    logic                  rd_go;
    logic [DATA_WIDTH-1:0] head;

    // The extra pointer bit separates a full channel from an empty one.
    always_comb begin
        ch_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_count[i*PW +: PW] = wr_ptr[i] - rd_ptr[i];
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = ((wr_ptr[i] - rd_ptr[i]) == PW'(DEPTH));
        end
    end

    always_comb begin
        cand     = ~empty;
        starving = '0;
        for (int i = 1; i < NUM_CH; i++)
            starving[i] = cand[i] && (age[i] == 4'(STARVE_LIMIT));
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (cand[i]) grant = 3'(i);
        // A starving channel overrides plain priority only in aging mode.
        if (arb_mode && (|starving)) begin
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (starving[i]) grant = 3'(i);
        end
        rd_go = rd_en && (|cand);
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (grant == 3'(i)) head = mem[i][rd_ptr[i][ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (wr_en[i] && !full[i])
                mem[i][wr_ptr[i][ADDR_WIDTH-1:0]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                age[i]    <= '0;
            end
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            overflow   <= '0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= rd_go;
            underflow  <= rd_en && !(|cand);
            overflow   <= wr_en & full;
            if (rd_go) begin
                dout    <= head;
                dout_ch <= grant;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en[i] && !full[i])
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (rd_go && (grant == 3'(i)))
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (i == 0 || empty[i])
                    age[i] <= '0;
                else if (arb_mode && rd_go) begin
                    if (grant == 3'(i))
                        age[i] <= '0;
                    else if (age[i] < 4'(STARVE_LIMIT))
                        age[i] <= age[i] + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_priority_nch.sv
// Scoreboard bench for fifo_priority_nch: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fifo_priority_nch;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int NCH   = 4;
    localparam int LIMIT = 4;
    localparam int PW    = AW + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    wr_en = '0;
    logic [NCH*DW-1:0] din = '0;
    logic              rd_en = 1'b0;
    logic              arb_mode = 1'b0;
    logic [DW-1:0]     dout;
    logic              dout_valid;
    logic [2:0]        dout_ch;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH*PW-1:0] ch_count;
    logic [NCH-1:0]    overflow;
    logic              underflow;

    fifo_priority_nch #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_CH(NCH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .arb_mode(arb_mode),
        .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch), .full(full), .empty(empty),
        .ch_count(ch_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [2:0]    ch;
    } exp_t;

    logic [DW-1:0] mq [NCH][$];
    int            mage [NCH];
    exp_t          sbq [$];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every dout_valid pulse must match the oldest predicted read.
    always @(negedge clk) begin
        if (rst && dout_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: dout=%0h ch=%0d with nothing predicted", dout, dout_ch);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_dout", 64'(dout), 64'(e.d));
                chk("sb_ch", 64'(dout_ch), 64'(e.ch));
            end
        end
    end

    function automatic int model_total();
        int t = 0;
        for (int i = 0; i < NCH; i++) t += mq[i].size();
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            mage[i] = 0;
        end
        sbq.delete();
    endtask

    // One clock: predict from the pre-edge state, step the model, check flags.
    task automatic tick();
        int             g;
        int             gs;
        bit             any;
        bit             go;
        bit             cand [NCH];
        logic [NCH-1:0] ovf_e;
        logic [NCH-1:0] wr_s;
        logic [NCH*DW-1:0] din_s;
        logic [NCH-1:0] emp_e;
        logic [NCH-1:0] ful_e;
        logic [NCH*PW-1:0] cnt_e;
        exp_t           e;
        any = 0; g = 0; gs = -1;
        wr_s = wr_en; din_s = din;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand[i] = (mq[i].size() != 0);
            if (cand[i]) begin any = 1; g = i; end
            if (i >= 1 && cand[i] && mage[i] == LIMIT) gs = i;
        end
        if (arb_mode && gs >= 0) g = gs;
        go = rd_en && any;
        for (int i = 0; i < NCH; i++) ovf_e[i] = wr_s[i] && (mq[i].size() == DEPTH);
        chk("underflow_pre", 64'(underflow), 64'(underflow));
        @(posedge clk);
        #1;
        chk("underflow", 64'(underflow), 64'(rd_en && !any));
        chk("dout_valid", 64'(dout_valid), 64'(go));
        chk("overflow", 64'(overflow), 64'(ovf_e));
        if (go) begin
            if (arb_mode) begin
                for (int i = 1; i < NCH; i++)
                    if (i == g) mage[i] = 0;
                    else if (cand[i] && mage[i] < LIMIT) mage[i]++;
            end
            e.d  = mq[g].pop_front();
            e.ch = 3'(g);
            sbq.push_back(e);
        end
        for (int i = 0; i < NCH; i++) begin
            if (wr_s[i] && !ovf_e[i]) mq[i].push_back(din_s[i*DW +: DW]);
            if (mq[i].size() == 0) mage[i] = 0;
            emp_e[i] = (mq[i].size() == 0);
            ful_e[i] = (mq[i].size() == DEPTH);
            cnt_e[i*PW +: PW] = PW'(mq[i].size());
        end
        chk("empty", 64'(empty), 64'(emp_e));
        chk("full", 64'(full), 64'(ful_e));
        chk("ch_count", 64'(ch_count), 64'(cnt_e));
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] d);
        wr_en = '0;
        wr_en[ch] = 1'b1;
        din[ch*DW +: DW] = d;
        tick();
        wr_en = '0;
    endtask

    task automatic rd_expect(input int ch, input logic [DW-1:0] d);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_dout", 64'(dout), 64'(d));
        chk("rd_ch", 64'(dout_ch), 64'(ch));
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && model_total() != 0; n++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_empty", 64'(empty), 64'hF);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_valid", 64'(dout_valid), 64'h0);
        rst = 1'b1;
        @(negedge clk);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("idle_underflow", 64'(underflow), 64'h1);
        chk("idle_dout", 64'(dout), 64'h0);

        // Strict priority order
        arb_mode = 1'b0;
        wr(3, 16'hA124);
        wr(3, 16'hA267);
        wr(1, 16'hB1B5);
        wr(0, 16'hC1F6);
        rd_expect(0, 16'hC1F6);
        rd_expect(1, 16'hB1B5);
        rd_expect(3, 16'hA124);
        rd_expect(3, 16'hA267);

        // Full, overflow and pointer wrap on channel 2
        for (int k = 1; k <= 9; k++) begin
            wr(2, DW'(k));
            if (k == 8) chk("ch2_full", 64'(full[2]), 64'h1);
            if (k == 9) chk("ch2_overflow", 64'(overflow[2]), 64'h1);
        end
        chk("ch2_count8", 64'(ch_count[2*PW +: PW]), 64'd8);
        for (int k = 1; k <= 8; k++) rd_expect(2, DW'(k));
        chk("ch2_empty", 64'(empty[2]), 64'h1);
        for (int k = 0; k < 3; k++) wr(2, 16'h00A0 + DW'(k));
        for (int k = 0; k < 3; k++) rd_expect(2, 16'h00A0 + DW'(k));

        // Aging: ch3 is served after LIMIT lost arbitrations
        arb_mode = 1'b1;
        wr(3, 16'hD9D9);
        wr(0, 16'h0100);
        for (int k = 0; k < 8; k++) begin
            wr_en = 4'b0001;
            din[0 +: DW] = 16'h0101 + DW'(k);
            rd_en = 1'b1;
            tick();
            if (k == LIMIT) begin
                chk("age_ch", 64'(dout_ch), 64'd3);
                chk("age_dout", 64'(dout), 64'hD9D9);
            end else begin
                chk("age_ch0", 64'(dout_ch), 64'd0);
            end
        end
        wr_en = '0;
        rd_en = 1'b0;
        drain();

        // Same traffic in strict mode never reaches ch3
        arb_mode = 1'b0;
        wr(3, 16'hD9D9);
        wr(0, 16'h0200);
        for (int k = 0; k < 8; k++) begin
            wr_en = 4'b0001;
            din[0 +: DW] = 16'h0201 + DW'(k);
            rd_en = 1'b1;
            tick();
            chk("strict_ch0", 64'(dout_ch), 64'd0);
        end
        wr_en = '0;
        rd_en = 1'b0;
        drain();

        // Simultaneous read and write on channel 1
        for (int k = 1; k <= 3; k++) wr(1, 16'h1000 + DW'(k));
        wr_en = 4'b0010;
        din[1*DW +: DW] = 16'h1004;
        rd_en = 1'b1;
        tick();
        chk("rw_count", 64'(ch_count[1*PW +: PW]), 64'd3);
        chk("rw_no_ovf", 64'(overflow), 64'h0);
        chk("rw_dout", 64'(dout), 64'h1001);
        wr_en = '0;
        rd_en = 1'b0;
        for (int k = 5; k <= 9; k++) wr(1, 16'h1000 + DW'(k));
        chk("ch1_full", 64'(full[1]), 64'h1);
        wr_en = 4'b0010;
        din[1*DW +: DW] = 16'h10FF;
        rd_en = 1'b1;
        tick();
        chk("fullrw_dout", 64'(dout), 64'h1002);
        chk("fullrw_ovf", 64'(overflow[1]), 64'h1);
        chk("fullrw_count", 64'(ch_count[1*PW +: PW]), 64'd7);
        wr_en = '0;
        rd_en = 1'b0;
        drain();

        // Asynchronous reset in the middle of a burst read
        for (int k = 0; k < 5; k++) wr(0, 16'h5000 + DW'(k));
        rd_en = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dout", 64'(dout), 64'h0);
        chk("arst_valid", 64'(dout_valid), 64'h0);
        chk("arst_empty", 64'(empty), 64'hF);
        chk("arst_count", 64'(ch_count), 64'h0);
        chk("arst_ch", 64'(dout_ch), 64'h0);
        rd_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("arst_underflow", 64'(underflow), 64'h1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) arb_mode = ~arb_mode;
            for (int i = 0; i < NCH; i++) begin
                wr_en[i] = ($urandom_range(0, 99) < 35);
                din[i*DW +: DW] = DW'($urandom);
            end
            rd_en = ($urandom_range(0, 99) < 55);
            tick();
        end
        wr_en = '0;
        drain();
        @(negedge clk);
        chk("sb_leftover", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
